// File: rtl/vga_line_prefetch.sv
// Ping-pong line prefetcher: fetches the next display line from SRAM while the current one is shown.
// Optional build macro VGA_PREFETCH_SCALE2_EN selects 2x pixel/line doubling from a 320x240 framebuffer.
module vga_line_prefetch #(
  parameter int          WORDS_PER_LINE = 20,
  parameter logic [31:0] BASE_ADDR      = 32'd0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        line_start,
  input  logic [8:0]  next_line,
  input  logic [9:0]  pixel_x,
  input  logic        pixel_rd,
  input  logic [31:0] SRAM_data_in,
  input  logic        SRAM_busy,
  output logic        read_en,
  output logic [31:0] word_address_dest,
  output logic [3:0]  byte_select,
  output logic        pixel_data,
  output logic        fetch_done,
  output logic        underrun
);

`ifdef VGA_PREFETCH_SCALE2_EN
  localparam int FETCH_WORDS = WORDS_PER_LINE / 2;
`else
  localparam int FETCH_WORDS = WORDS_PER_LINE;
`endif
  localparam int CW = $clog2(WORDS_PER_LINE);
  localparam logic [CW-1:0] LAST_WORD = CW'(FETCH_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t         state;
  logic [31:0]    line_buf [2][WORDS_PER_LINE];
  logic           front_sel;
  logic           pending_start;
  logic [CW-1:0]  word_cnt;
  logic [31:0]    cur_base;
  logic [31:0]    new_base;
  logic           capture;
  logic [4:0]     rd_word;
  logic [4:0]     rd_bit;
  logic           rd_in_range;

  always_comb begin
    new_base = 32'd0;
    rd_word  = 5'd0;
    rd_bit   = 5'd0;
`ifdef VGA_PREFETCH_SCALE2_EN
    new_base = BASE_ADDR + 32'(next_line[8:1]) * 32'(FETCH_WORDS);
    rd_word  = {1'b0, pixel_x[9:6]};
    rd_bit   = pixel_x[5:1];
`else
    new_base = BASE_ADDR + 32'(next_line) * 32'(FETCH_WORDS);
    rd_word  = pixel_x[9:5];
    rd_bit   = pixel_x[4:0];
`endif
    rd_in_range = ({27'd0, rd_word} < 32'(FETCH_WORDS));
    // Data of an interrupted transaction is dropped, never written to the new back buffer.
    capture = nrst && (state == WAIT) && !SRAM_busy && !pending_start && !line_start;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state             <= IDLE;
      word_cnt          <= '0;
      front_sel         <= 1'b0;
      pending_start     <= 1'b0;
      cur_base          <= 32'd0;
      read_en           <= 1'b0;
      word_address_dest <= 32'd0;
      byte_select       <= 4'h0;
      fetch_done        <= 1'b0;
      underrun          <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (line_start) begin
        front_sel <= ~front_sel;
        cur_base  <= new_base;
      end
      case (state)
        IDLE, DONE: begin
          if (line_start) begin
            state             <= REQ;
            word_cnt          <= '0;
            word_address_dest <= new_base;
            read_en           <= 1'b1;
            byte_select       <= 4'hF;
            fetch_done        <= 1'b0;
          end
        end
        REQ: begin
          if (line_start) begin
            underrun          <= 1'b1;
            word_cnt          <= '0;
            word_address_dest <= new_base;
          end else begin
            state       <= WAIT;
            read_en     <= 1'b0;
            byte_select <= 4'h0;
          end
        end
        WAIT: begin
          if (line_start) underrun <= 1'b1;
          if (SRAM_busy) begin
            if (line_start) pending_start <= 1'b1;
          end else if (line_start || pending_start) begin
            // Outstanding read has finished; restart on the most recently latched line.
            state             <= REQ;
            pending_start     <= 1'b0;
            word_cnt          <= '0;
            word_address_dest <= line_start ? new_base : cur_base;
            read_en           <= 1'b1;
            byte_select       <= 4'hF;
          end else if (word_cnt == LAST_WORD) begin
            state      <= DONE;
            fetch_done <= 1'b1;
          end else begin
            state             <= REQ;
            word_cnt          <= word_cnt + 1'b1;
            word_address_dest <= word_address_dest + 32'd1;
            read_en           <= 1'b1;
            byte_select       <= 4'hF;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (capture) line_buf[~front_sel][word_cnt] <= SRAM_data_in;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pixel_data <= 1'b0;
    end else if (pixel_rd && rd_in_range) begin
      pixel_data <= line_buf[front_sel][rd_word][rd_bit];
    end else begin
      pixel_data <= 1'b0;
    end
  end

endmodule
